fpu_sqrt_digit_recurrence: RTL and testbench

FPU_SQRT_DIGIT_RECURRENCE -- requirements
Module: fpu_sqrt_digit_recurrence

---
 rtl/fpu_sqrt_digit_recurrence.sv | 182 ++++++++++++++++++
 tb/tb_fpu_sqrt_digit_recurrence.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sqrt_digit_recurrence.sv
// Radix-2 restoring square root for {sign, exponent, explicit-integer significand} floats.
// Normal operands: one root bit per cycle, done MANT_W+3 cycles after acceptance; specials resolve after one cycle.
module fpu_sqrt_digit_recurrence #(
    parameter int EXP_W  = 15,
    parameter int MANT_W = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            rounding_mode,
    input  logic [EXP_W+MANT_W:0] s_in,
    output logic [EXP_W+MANT_W:0] sqrt_out,
    output logic                  done,
    output logic                  busy,
    output logic                  error,
    output logic                  flag_inexact,
    output logic                  flag_denormal
);
    localparam int W     = 1 + EXP_W + MANT_W;
    localparam int CNT_W = $clog2(MANT_W + 1);
    localparam int RAD_W = 2 * (MANT_W + 1);
    localparam logic [EXP_W:0]    BIAS    = {2'b00, {(EXP_W-1){1'b1}}};
    localparam logic [MANT_W-1:0] INT_BIT = {1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [W-1:0]      QNAN    = {1'b1, {EXP_W{1'b1}}, 2'b11, {(MANT_W-2){1'b0}}};
    localparam logic [W-1:0]      QUIET   = {{(EXP_W+2){1'b0}}, 1'b1, {(MANT_W-2){1'b0}}};
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(MANT_W);

    typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       op_q, op_d;
    logic [1:0]         rm_q, rm_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [MANT_W+2:0]  rem_q, rem_d;
    logic [MANT_W:0]    root_q, root_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       sqrt_out_q, sqrt_out_d;
    logic               error_q, error_d;
    logic               inexact_q, inexact_d;
    logic               denorm_q, denorm_d;

    logic               op_sign;
    logic [EXP_W-1:0]   op_exp;
    logic [MANT_W-1:0]  op_sig;
    logic [EXP_W:0]     exp_sum;
    logic [MANT_W:0]    rad_init;
    logic [MANT_W+2:0]  rem_sh, trial;
    logic               take, guard, sticky, inc;
    logic [MANT_W:0]    sig_sum;

    assign op_sign  = op_q[W-1];
    assign op_exp   = op_q[MANT_W +: EXP_W];
    assign op_sig   = op_q[MANT_W-1:0];
    // Odd biased exponent means even unbiased exponent: radicand stays in [1,2), otherwise doubled.
    assign exp_sum  = {1'b0, op_exp} + BIAS - {{EXP_W{1'b0}}, ~op_exp[0]};
    assign rad_init = op_exp[0] ? {1'b0, op_sig} : {op_sig, 1'b0};

    assign rem_sh = {rem_q[MANT_W:0], rad_q[RAD_W-1 -: 2]};
    assign trial  = {root_q, 2'b01};
    assign take   = rem_sh >= trial;

    assign guard  = root_q[0];
    assign sticky = |rem_q;
    always_comb begin
        case (rm_q)
            2'b00:   inc = guard & (sticky | root_q[1]);
            2'b10:   inc = guard | sticky;
            default: inc = 1'b0;
        endcase
    end
    assign sig_sum = {1'b0, root_q[MANT_W:1]} + {{MANT_W{1'b0}}, inc};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rm_d       = rm_q;
        rad_d      = rad_q;
        rem_d      = rem_q;
        root_d     = root_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        sqrt_out_d = sqrt_out_q;
        error_d    = error_q;
        inexact_d  = inexact_q;
        denorm_d   = denorm_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    op_d      = s_in;
                    rm_d      = rounding_mode;
                    error_d   = 1'b0;
                    inexact_d = 1'b0;
                    denorm_d  = 1'b0;
                    state_d   = PREP;
                end
            end
            PREP: begin
                state_d = DONE;
                if (&op_exp) begin
                    if (op_sig == INT_BIT) begin
                        sqrt_out_d = op_sign ? QNAN : op_q;
                        error_d    = op_sign;
                    end else begin
                        sqrt_out_d = op_q | QUIET;
                        error_d    = ~op_sig[MANT_W-2];
                    end
                end else if (op_exp == '0) begin
                    sqrt_out_d = {op_sign, {(W-1){1'b0}}};
                    denorm_d   = |op_sig;
                    inexact_d  = |op_sig;
                end else if (op_sign || !op_sig[MANT_W-1]) begin
                    sqrt_out_d = QNAN;
                    error_d    = 1'b1;
                end else begin
                    rad_d   = {rad_init, {(MANT_W+1){1'b0}}};
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    exp_d   = EXP_W'(exp_sum >> 1);
                    state_d = ITER;
                end
            end
            ITER: begin
                rem_d   = take ? rem_sh - trial : rem_sh;
                root_d  = {root_q[MANT_W-1:0], take};
                rad_d   = {rad_q[RAD_W-3:0], 2'b00};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ROUND;
            end
            ROUND: begin
                inexact_d = guard | sticky;
                if (sig_sum[MANT_W])
                    sqrt_out_d = {1'b0, exp_q + {{(EXP_W-1){1'b0}}, 1'b1}, INT_BIT};
                else
                    sqrt_out_d = {1'b0, exp_q, sig_sum[MANT_W-1:0]};
                state_d = DONE;
            end
            DONE: begin
                if (!enable) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            rm_q       <= '0;
            rad_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            exp_q      <= '0;
            cnt_q      <= '0;
            sqrt_out_q <= '0;
            error_q    <= 1'b0;
            inexact_q  <= 1'b0;
            denorm_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rm_q       <= rm_d;
            rad_q      <= rad_d;
            rem_q      <= rem_d;
            root_q     <= root_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            sqrt_out_q <= sqrt_out_d;
            error_q    <= error_d;
            inexact_q  <= inexact_d;
            denorm_q   <= denorm_d;
        end
    end

    assign sqrt_out      = sqrt_out_q;
    assign done          = (state_q == DONE);
    assign busy          = (state_q == PREP) || (state_q == ITER) || (state_q == ROUND);
    assign error         = error_q;
    assign flag_inexact  = inexact_q;
    assign flag_denormal = denorm_q;
endmodule

// File: tb/tb_fpu_sqrt_digit_recurrence.sv
// Bench for fpu_sqrt_digit_recurrence: directed and random operands against an arithmetic reference model.
module tb_fpu_sqrt_digit_recurrence;
    localparam logic [79:0] QNAN = 80'hFFFF_C000000000000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  rounding_mode;
    logic [79:0] s_in;
    logic [79:0] sqrt_out;
    logic        done, busy, error, flag_inexact, flag_denormal;

    int n_total = 0;
    int n_pass  = 0;
    logic [79:0] last_out;
    logic        last_ix;

    always #5 clk = ~clk;

    fpu_sqrt_digit_recurrence dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rounding_mode (rounding_mode),
        .s_in          (s_in),
        .sqrt_out      (sqrt_out),
        .done          (done),
        .busy          (busy),
        .error         (error),
        .flag_inexact  (flag_inexact),
        .flag_denormal (flag_denormal)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: root found as the largest integer whose square fits, then rounded by mode.
    task automatic model(input logic [79:0] x, input logic [1:0] rm, output logic [79:0] r,
                         output logic e, output logic ix, output logic dn, output int lat);
        logic        sign;
        logic [14:0] ex;
        logic [63:0] sg, mant;
        logic [64:0] rr, sum;
        logic [129:0] n, q, t, one;
        logic        g, s, inc;
        int          e2;
        logic [14:0] e15;
        sign = x[79]; ex = x[78:64]; sg = x[63:0];
        lat = 1; e = 1'b0; ix = 1'b0; dn = 1'b0;
        if (ex == 15'h7FFF) begin
            if (sg == 64'h8000_0000_0000_0000) begin
                r = sign ? QNAN : x;
                e = sign;
            end else begin
                r = x;
                r[62] = 1'b1;
                e = ~x[62];
            end
        end else if (ex == 15'h0) begin
            r = {sign, 79'b0};
            ix = (sg != 0);
            dn = (sg != 0);
        end else if (sign || !sg[63]) begin
            r = QNAN;
            e = 1'b1;
        end else begin
            lat = 67;
            rr = ex[0] ? {1'b0, sg} : {sg, 1'b0};
            n = {rr, 65'b0};
            q = '0;
            one = 130'd1;
            for (int b = 64; b >= 0; b--) begin
                t = q | (one << b);
                if (t * t <= n) q = t;
            end
            g = q[0];
            s = (q * q != n);
            mant = q[64:1];
            case (rm)
                2'b00:   inc = g & (s | mant[0]);
                2'b10:   inc = g | s;
                default: inc = 1'b0;
            endcase
            e2 = (int'(ex) + 16383 - (ex[0] ? 0 : 1)) / 2;
            sum = {1'b0, mant} + {64'b0, inc};
            if (sum[64]) begin
                mant = 64'h8000_0000_0000_0000;
                e2 = e2 + 1;
            end else begin
                mant = sum[63:0];
            end
            e15 = e2[14:0];
            r = {1'b0, e15, mant};
            ix = g | s;
        end
    endtask

    task automatic run_op(input string tag, input logic [79:0] x, input logic [1:0] rm, input int hold);
        logic [79:0] exp_r;
        logic        exp_e, exp_ix, exp_dn;
        int          exp_lat, cyc;
        model(x, rm, exp_r, exp_e, exp_ix, exp_dn, exp_lat);
        @(negedge clk);
        s_in = x; rounding_mode = rm; enable = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 200);
        check({tag, " latency"}, 80'(cyc), 80'(exp_lat));
        check({tag, " result"}, sqrt_out, exp_r);
        check({tag, " error"}, 80'(error), 80'(exp_e));
        check({tag, " inexact"}, 80'(flag_inexact), 80'(exp_ix));
        check({tag, " denormal"}, 80'(flag_denormal), 80'(exp_dn));
        check({tag, " busy_at_done"}, 80'(busy), 80'd0);
        last_out = sqrt_out;
        last_ix  = flag_inexact;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold_done"}, 80'(done), 80'd1);
            check({tag, " hold_out"}, sqrt_out, exp_r);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check({tag, " done_drop"}, 80'(done), 80'd0);
        check({tag, " idle_busy"}, 80'(busy), 80'd0);
    endtask

    initial begin
        logic [79:0] x;
        logic [63:0] sg;
        logic [14:0] ex;
        reset = 1'b1; enable = 1'b0; rounding_mode = 2'b00; s_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst out", sqrt_out, 80'd0);
        check("rst done", 80'(done), 80'd0);
        check("rst busy", 80'(busy), 80'd0);
        check("rst error", 80'(error), 80'd0);
        check("rst inexact", 80'(flag_inexact), 80'd0);
        check("rst denormal", 80'(flag_denormal), 80'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("four", 80'h4001_8000000000000000, 2'b00, 10);
        check("four const", last_out, 80'h4000_8000000000000000);
        run_op("two_rne", 80'h4000_8000000000000000, 2'b00, 0);
        check("two_rne const", last_out, 80'h3FFF_B504F333F9DE6484);
        check("two_rne inexact const", 80'(last_ix), 80'd1);
        run_op("two_up", 80'h4000_8000000000000000, 2'b10, 0);
        check("two_up const", last_out, 80'h3FFF_B504F333F9DE6485);
        run_op("two_dn", 80'h4000_8000000000000000, 2'b01, 0);
        run_op("two_rz", 80'h4000_8000000000000000, 2'b11, 0);
        run_op("quarter", 80'h3FFD_8000000000000000, 2'b00, 0);
        check("quarter const", last_out, 80'h3FFE_8000000000000000);
        run_op("neg_one", 80'hBFFF_8000000000000000, 2'b00, 0);
        check("neg_one const", last_out, 80'hFFFF_C000000000000000);
        run_op("neg_zero", 80'h8000_0000000000000000, 2'b00, 0);
        check("neg_zero const", last_out, 80'h8000_0000000000000000);
        run_op("pos_zero", 80'h0000_0000000000000000, 2'b00, 0);
        run_op("pos_inf", 80'h7FFF_8000000000000000, 2'b00, 0);
        run_op("neg_inf", 80'hFFFF_8000000000000000, 2'b00, 0);
        run_op("qnan", 80'h7FFF_C000000000000123, 2'b00, 0);
        run_op("snan", 80'h7FFF_8000000000000001, 2'b00, 0);
        check("snan const", last_out, 80'h7FFF_C000000000000001);
        run_op("denormal", 80'h0000_0000000000000123, 2'b00, 0);
        run_op("unnormal", 80'h3FFF_4000000000000000, 2'b00, 0);
        run_op("carry_up", 80'h4000_FFFFFFFFFFFFFFFF, 2'b10, 0);
        run_op("one_rz", 80'h3FFF_8000000000000000, 2'b11, 0);
        run_op("max_odd", 80'h7FFE_FFFFFFFFFFFFFFFF, 2'b00, 0);
        run_op("min_norm", 80'h0001_8000000000000000, 2'b00, 0);

        for (int k = 0; k < 16; k++) begin
            sg = {$urandom, $urandom};
            sg[63] = 1'b1;
            ex = 15'($urandom_range(1, 32766));
            x = {1'b0, ex, sg};
            run_op($sformatf("rand%0d", k), x, 2'($urandom_range(0, 3)), 0);
        end

        // Abort an operation mid-recurrence with reset.
        @(negedge clk);
        s_in = 80'h4000_8000000000000000; rounding_mode = 2'b00; enable = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        check("mid busy", 80'(busy), 80'd1);
        @(negedge clk);
        reset = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        check("mid rst out", sqrt_out, 80'd0);
        check("mid rst done", 80'(done), 80'd0);
        check("mid rst busy", 80'(busy), 80'd0);
        check("mid rst error", 80'(error), 80'd0);
        check("mid rst inexact", 80'(flag_inexact), 80'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("four_after_rst", 80'h4001_8000000000000000, 2'b00, 0);
        check("four_after_rst const", last_out, 80'h4000_8000000000000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
